// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state enum, forward-select constants and producer match helper
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // A producer only counts if it writes a real register (x0 writes are discarded).
  function automatic logic hz_match(input logic       we,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return we && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - ALU operand forwarding select, EX_MEM result preferred over MEM_WB
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_mem_rd_i,
  input  logic       ex_mem_we_i,
  input  logic [4:0] mem_wb_rd_i,
  input  logic       mem_wb_we_i,
  input  logic [4:0] id_ex_rs1_i,
  input  logic [4:0] id_ex_rs2_i,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_mem_we_i && (ex_mem_rd_i != 5'd0) && (ex_mem_rd_i == rs)) begin
      return FWD_EX_MEM;
    end else if (mem_wb_we_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rs)) begin
      return FWD_MEM_WB;
    end
    return FWD_NONE;
  endfunction

  always_comb begin
    forward_a_o = fwd_sel(id_ex_rs1_i);
    forward_b_o = fwd_sel(id_ex_rs2_i);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: branch flush FSM, stalls, stall counter
// Define HAZARD_CTRL_FORWARD_EN to enable operand forwarding (only load-use then stalls).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 2,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             IF_ID_rs1,
  input  logic [4:0]             IF_ID_rs2,
  input  logic [4:0]             ID_EX_rs1,
  input  logic [4:0]             ID_EX_rs2,
  input  logic [4:0]             ID_EX_rd,
  input  logic                   ID_EX_MemRead,
  input  logic                   ID_EX_RegWrite,
  input  logic [4:0]             EX_MEM_rd,
  input  logic                   EX_MEM_RegWrite,
  input  logic [4:0]             MEM_WB_rd,
  input  logic                   MEM_WB_RegWrite,
  input  logic                   branch_taken,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  hz_state_e              state_q, state_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   load_use;
  logic                   stall;
  logic [1:0]             fwd_a_raw;
  logic [1:0]             fwd_b_raw;

  assign load_use = hz_match(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2);

`ifdef HAZARD_CTRL_FORWARD_EN
  logic unused_regwrite;
  assign unused_regwrite = ID_EX_RegWrite;
  assign stall = load_use;

  forward_unit u_forward_unit (
    .ex_mem_rd_i (EX_MEM_rd),
    .ex_mem_we_i (EX_MEM_RegWrite),
    .mem_wb_rd_i (MEM_WB_rd),
    .mem_wb_we_i (MEM_WB_RegWrite),
    .id_ex_rs1_i (ID_EX_rs1),
    .id_ex_rs2_i (ID_EX_rs2),
    .forward_a_o (fwd_a_raw),
    .forward_b_o (fwd_b_raw)
  );
`else
  // Without forwarding every in-flight producer blocks decode until it retires.
  logic unused_rs;
  assign unused_rs = ^{ID_EX_rs1, ID_EX_rs2};
  assign stall = load_use
              || hz_match(ID_EX_RegWrite,  ID_EX_rd,  IF_ID_rs1, IF_ID_rs2)
              || hz_match(EX_MEM_RegWrite, EX_MEM_rd, IF_ID_rs1, IF_ID_rs2)
              || hz_match(MEM_WB_RegWrite, MEM_WB_rd, IF_ID_rs1, IF_ID_rs2);
  assign fwd_a_raw = FWD_NONE;
  assign fwd_b_raw = FWD_NONE;
`endif

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          if (BR_FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = 3'(BR_FLUSH_CYCLES - 1);
          end
        end else if (stall) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
      end
      FLUSH: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q == 3'd1) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!reset) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      flush_cnt_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign forward_a   = reset ? fwd_a_raw : FWD_NONE;
  assign forward_b   = reset ? fwd_b_raw : FWD_NONE;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic       ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite, branch_taken;
  logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush;
  logic [1:0] forward_a, forward_b;
  logic [3:0] stall_count;
  logic       pc_write_1, IF_ID_write_1, IF_ID_flush_1, ID_EX_flush_1;
  logic [1:0] forward_a_1, forward_b_1;
  logic [3:0] stall_count_1;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.BR_FLUSH_CYCLES(2), .STALL_CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall_count(stall_count)
  );

  hazard_ctrl #(.BR_FLUSH_CYCLES(1), .STALL_CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write_1), .IF_ID_write(IF_ID_write_1),
    .IF_ID_flush(IF_ID_flush_1), .ID_EX_flush(ID_EX_flush_1),
    .forward_a(forward_a_1), .forward_b(forward_b_1), .stall_count(stall_count_1)
  );

  task automatic clear_inputs();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; ID_EX_rs1 = 5'd0; ID_EX_rs2 = 5'd0; ID_EX_rd = 5'd0;
    EX_MEM_rd = 5'd0; MEM_WB_rd = 5'd0; ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0;
    EX_MEM_RegWrite = 1'b0; MEM_WB_RegWrite = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_load_use();
    branch_taken = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_rd = 5'd7; ID_EX_rs1 = 5'd7; ID_EX_rs2 = 5'd7;
    #1;
    checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write actual=%b expected=0", pc_write); end
    checks++; if (IF_ID_write !== 1'b0) begin failures++; $display("FAIL rst_if_id_write actual=%b expected=0", IF_ID_write); end
    checks++; if (IF_ID_flush !== 1'b0) begin failures++; $display("FAIL rst_if_id_flush actual=%b expected=0", IF_ID_flush); end
    checks++; if (ID_EX_flush !== 1'b0) begin failures++; $display("FAIL rst_id_ex_flush actual=%b expected=0", ID_EX_flush); end
    checks++; if (forward_a !== 2'b00) begin failures++; $display("FAIL rst_forward_a actual=%b expected=00", forward_a); end
    checks++; if (forward_b !== 2'b00) begin failures++; $display("FAIL rst_forward_b actual=%b expected=00", forward_b); end
    step();
    step();
    checks++; if (stall_count !== 4'd0) begin failures++; $display("FAIL rst_stall_count actual=%0d expected=0", stall_count); end
    clear_inputs();
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_idle();
    clear_inputs();
    #1;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL idle_pc_write actual=%b expected=1", pc_write); end
    checks++; if (IF_ID_write !== 1'b1) begin failures++; $display("FAIL idle_if_id_write actual=%b expected=1", IF_ID_write); end
    checks++; if ({IF_ID_flush, ID_EX_flush} !== 2'b00) begin failures++; $display("FAIL idle_flushes actual=%b expected=00", {IF_ID_flush, ID_EX_flush}); end
    step();
    checks++; if (stall_count !== 4'd0) begin failures++; $display("FAIL idle_stall_count actual=%0d expected=0", stall_count); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_load_use();
    #1;
    checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL lu_pc_write actual=%b expected=0", pc_write); end
    checks++; if (IF_ID_write !== 1'b0) begin failures++; $display("FAIL lu_if_id_write actual=%b expected=0", IF_ID_write); end
    checks++; if (IF_ID_flush !== 1'b0) begin failures++; $display("FAIL lu_if_id_flush actual=%b expected=0", IF_ID_flush); end
    checks++; if (ID_EX_flush !== 1'b1) begin failures++; $display("FAIL lu_id_ex_flush actual=%b expected=1", ID_EX_flush); end
    step();
    clear_inputs();
    exp_cnt = exp_cnt + 1;
    #1;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL lu_release actual=%b expected=1", pc_write); end
    checks++; if (stall_count !== 4'(exp_cnt)) begin failures++; $display("FAIL lu_stall_count actual=%0d expected=%0d", stall_count, exp_cnt); end
    checks++; if (stall_count_1 !== 4'(exp_cnt)) begin failures++; $display("FAIL lu_stall_count_1 actual=%0d expected=%0d", stall_count_1, exp_cnt); end
  endtask

  task automatic test_dependency();
    logic exp_pw;
    exp_pw = FWD;
    clear_inputs();
    IF_ID_rs1 = 5'd3; ID_EX_rd = 5'd3; ID_EX_RegWrite = 1'b1;
    #1;
    checks++; if (pc_write !== exp_pw) begin failures++; $display("FAIL dep_id_ex actual=%b expected=%b", pc_write, exp_pw); end
    step();
    ID_EX_rd = 5'd0; ID_EX_RegWrite = 1'b0; EX_MEM_rd = 5'd3; EX_MEM_RegWrite = 1'b1;
    #1;
    checks++; if (pc_write !== exp_pw) begin failures++; $display("FAIL dep_ex_mem actual=%b expected=%b", pc_write, exp_pw); end
    step();
    EX_MEM_rd = 5'd0; EX_MEM_RegWrite = 1'b0; MEM_WB_rd = 5'd3; MEM_WB_RegWrite = 1'b1;
    #1;
    checks++; if (pc_write !== exp_pw) begin failures++; $display("FAIL dep_mem_wb actual=%b expected=%b", pc_write, exp_pw); end
    step();
    clear_inputs();
    IF_ID_rs1 = 5'd3;
    #1;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL dep_release actual=%b expected=1", pc_write); end
    exp_cnt = exp_cnt + (FWD ? 0 : 3);
    checks++; if (stall_count !== 4'(exp_cnt)) begin failures++; $display("FAIL dep_stall_count actual=%0d expected=%0d", stall_count, exp_cnt); end
  endtask

  task automatic test_x0();
    clear_inputs();
    EX_MEM_rd = 5'd0; EX_MEM_RegWrite = 1'b1; MEM_WB_rd = 5'd0; MEM_WB_RegWrite = 1'b1;
    ID_EX_rs1 = 5'd0; IF_ID_rs1 = 5'd0;
    #1;
    checks++; if (forward_a !== 2'b00) begin failures++; $display("FAIL x0_forward_a actual=%b expected=00", forward_a); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL x0_no_stall actual=%b expected=1", pc_write); end
    step();
  endtask

  task automatic test_fwd_priority();
    logic [1:0] exp_ex, exp_wb;
    exp_ex = FWD ? 2'b10 : 2'b00;
    exp_wb = FWD ? 2'b01 : 2'b00;
    clear_inputs();
    IF_ID_rs1 = 5'd10;
    EX_MEM_rd = 5'd7; EX_MEM_RegWrite = 1'b1; MEM_WB_rd = 5'd7; MEM_WB_RegWrite = 1'b1;
    ID_EX_rs1 = 5'd7; ID_EX_rs2 = 5'd7;
    #1;
    checks++; if (forward_a !== exp_ex) begin failures++; $display("FAIL fwd_prio_a actual=%b expected=%b", forward_a, exp_ex); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL fwd_no_stall actual=%b expected=1", pc_write); end
    EX_MEM_rd = 5'd9; ID_EX_rs2 = 5'd9;
    #1;
    checks++; if (forward_a !== exp_wb) begin failures++; $display("FAIL fwd_memwb_a actual=%b expected=%b", forward_a, exp_wb); end
    checks++; if (forward_b !== exp_ex) begin failures++; $display("FAIL fwd_exmem_b actual=%b expected=%b", forward_b, exp_ex); end
    EX_MEM_RegWrite = 1'b0;
    #1;
    checks++; if (forward_b !== 2'b00) begin failures++; $display("FAIL fwd_b_no_we actual=%b expected=00", forward_b); end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_taken = 1'b1;
    #1;
    checks++; if ({IF_ID_flush, ID_EX_flush} !== 2'b11) begin failures++; $display("FAIL br_c0_flushes actual=%b expected=11", {IF_ID_flush, ID_EX_flush}); end
    checks++; if ({pc_write, IF_ID_write} !== 2'b11) begin failures++; $display("FAIL br_c0_writes actual=%b expected=11", {pc_write, IF_ID_write}); end
    checks++; if (IF_ID_flush_1 !== 1'b1) begin failures++; $display("FAIL br1_c0_flush actual=%b expected=1", IF_ID_flush_1); end
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (IF_ID_flush_1 !== 1'b0) begin failures++; $display("FAIL br1_c1_flush actual=%b expected=0", IF_ID_flush_1); end
    set_load_use();
    branch_taken = 1'b1;
    #1;
    checks++; if ({IF_ID_flush, ID_EX_flush} !== 2'b11) begin failures++; $display("FAIL br_c1_flushes actual=%b expected=11", {IF_ID_flush, ID_EX_flush}); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL br_c1_hazard_ignored actual=%b expected=1", pc_write); end
    step();
    clear_inputs();
    #1;
    checks++; if ({IF_ID_flush, ID_EX_flush} !== 2'b00) begin failures++; $display("FAIL br_c2_run actual=%b expected=00", {IF_ID_flush, ID_EX_flush}); end
    checks++; if (stall_count !== 4'(exp_cnt)) begin failures++; $display("FAIL br_stall_count actual=%0d expected=%0d", stall_count, exp_cnt); end
  endtask

  task automatic test_branch_and_stall();
    clear_inputs();
    set_load_use();
    branch_taken = 1'b1;
    #1;
    checks++; if ({IF_ID_flush, ID_EX_flush} !== 2'b11) begin failures++; $display("FAIL bs_flushes actual=%b expected=11", {IF_ID_flush, ID_EX_flush}); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL bs_pc_write actual=%b expected=1", pc_write); end
    step();
    checks++; if (stall_count !== 4'(exp_cnt)) begin failures++; $display("FAIL bs_stall_count actual=%0d expected=%0d", stall_count, exp_cnt); end
    clear_inputs();
    step();
    checks++; if (IF_ID_flush !== 1'b0) begin failures++; $display("FAIL bs_back_to_run actual=%b expected=0", IF_ID_flush); end
  endtask

  task automatic test_saturation();
    clear_inputs();
    set_load_use();
    repeat (20) step();
    clear_inputs();
    exp_cnt = 15;
    #1;
    checks++; if (stall_count !== 4'd15) begin failures++; $display("FAIL sat_stall_count actual=%0d expected=15", stall_count); end
    checks++; if (stall_count_1 !== 4'd15) begin failures++; $display("FAIL sat_stall_count_1 actual=%0d expected=15", stall_count_1); end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (IF_ID_flush !== 1'b1) begin failures++; $display("FAIL rmf_in_flush actual=%b expected=1", IF_ID_flush); end
    reset = 1'b0;
    #1;
    checks++; if ({pc_write, IF_ID_flush, ID_EX_flush} !== 3'b000) begin failures++; $display("FAIL rmf_outputs actual=%b expected=000", {pc_write, IF_ID_flush, ID_EX_flush}); end
    checks++; if (stall_count !== 4'd0) begin failures++; $display("FAIL rmf_count_async actual=%0d expected=0", stall_count); end
    step();
    #2;
    reset = 1'b1;
    exp_cnt = 0;
    #1;
    checks++; if ({pc_write, IF_ID_flush} !== 2'b10) begin failures++; $display("FAIL rmf_run actual=%b expected=10", {pc_write, IF_ID_flush}); end
    step();
    checks++; if (IF_ID_flush !== 1'b0) begin failures++; $display("FAIL rmf_run_edge actual=%b expected=0", IF_ID_flush); end
    checks++; if (stall_count !== 4'd0) begin failures++; $display("FAIL rmf_stall_count actual=%0d expected=0", stall_count); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    step();
    test_reset();
    test_idle();
    test_load_use();
    test_dependency();
    test_x0();
    test_fwd_priority();
    test_branch();
    test_branch_and_stall();
    test_saturation();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter BR_FLUSH_CYCLES, default 2, range 1..7: cycles IF_ID/ID_EX are flushed after a taken branch.
REQ-002 SHALL have parameter STALL_CNT_W, default 16: width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports IF_ID_rs1 and IF_ID_rs2, input, 5 each: source registers of the instruction in decode.
REQ-006 SHALL have ports ID_EX_rs1, ID_EX_rs2 and ID_EX_rd, input, 5 each: register fields of the instruction in execute.
REQ-007 SHALL have ports ID_EX_MemRead and ID_EX_RegWrite, input, 1 each: execute-stage control bits.
REQ-008 SHALL have ports EX_MEM_rd, input, 5, and EX_MEM_RegWrite, input, 1: memory-stage producer.
REQ-009 SHALL have ports MEM_WB_rd, input, 5, and MEM_WB_RegWrite, input, 1: writeback-stage producer.
REQ-010 SHALL have port branch_taken, input, 1: branch resolved taken in execute this cycle.
REQ-011 SHALL have ports pc_write and IF_ID_write, output, 1 each: PC and IF_ID load enables.
REQ-012 SHALL have ports IF_ID_flush and ID_EX_flush, output, 1 each: clear the register or insert a bubble (all control bits zero).
REQ-013 SHALL have ports forward_a and forward_b, output, 2 each: ALU operand source select.
REQ-014 SHALL have port stall_count, output, STALL_CNT_W: saturating count of stalled cycles.

Function
REQ-015 SHALL implement FSM states RUN and FLUSH, plus a 3-bit down-counter flush_cnt.
REQ-016 SHALL define a hazard match as producer write-enable = 1, producer rd != 0, and producer rd equal to IF_ID_rs1 or IF_ID_rs2.
REQ-017 SHALL, in RUN with branch_taken=1, drive pc_write=1, IF_ID_write=1, IF_ID_flush=1 and ID_EX_flush=1 in the same cycle.
REQ-018 SHALL, on the branch of REQ-017, move to FLUSH with flush_cnt=BR_FLUSH_CYCLES-1 when BR_FLUSH_CYCLES>1, and otherwise stay in RUN.
REQ-019 SHALL, in FLUSH, drive IF_ID_flush=1, ID_EX_flush=1, pc_write=1 and IF_ID_write=1, and ignore branch_taken and all hazards.
REQ-020 SHALL, in FLUSH, decrement flush_cnt each cycle and enter RUN on the cycle flush_cnt is 1.
REQ-021 SHALL, in RUN with branch_taken=0 and a load-use match (ID_EX_MemRead=1 with an ID_EX_rd match), drive pc_write=0, IF_ID_write=0, IF_ID_flush=0 and ID_EX_flush=1.
REQ-022 SHALL give branch_taken priority over any stall when both occur in the same cycle.
REQ-023 SHALL, in RUN with no branch and no stall, drive pc_write=1, IF_ID_write=1 and both flushes 0.
REQ-024 SHALL make all pc_write/IF_ID_write/flush outputs combinational from state and inputs, with zero-cycle latency.
REQ-025 SHALL increment stall_count by 1 each cycle pc_write=0 while out of reset, and hold it at all-ones once reached.

Reset
REQ-026 SHALL, while reset=0, force state=RUN, flush_cnt=0 and stall_count=0.
REQ-027 SHALL, while reset=0, drive pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=0, forward_a=00 and forward_b=00.
REQ-028 SHALL, when reset is asserted mid-FLUSH, abandon the remaining flush cycles, and SHALL resume in RUN on the first clock edge after deassertion.

Configuration
REQ-029 SHALL, with macro HAZARD_CTRL_FORWARD_EN defined, set forward_a to 10 when EX_MEM_RegWrite=1, EX_MEM_rd!=0 and EX_MEM_rd==ID_EX_rs1.
REQ-030 SHALL, under HAZARD_CTRL_FORWARD_EN, otherwise set forward_a to 01 on the same condition against MEM_WB, otherwise 00; forward_b SHALL be derived the same way from ID_EX_rs2.
REQ-031 SHALL, without HAZARD_CTRL_FORWARD_EN, tie forward_a and forward_b to 00.
REQ-032 SHALL, without HAZARD_CTRL_FORWARD_EN, extend the REQ-021 stall to any match against ID_EX (RegWrite), EX_MEM or MEM_WB.
REQ-033 SHALL, in the configuration of REQ-032, re-evaluate the stall every cycle until no match remains (at most 3 cycles per dependency).

Structure
REQ-034 SHALL place the state enum (RUN/FLUSH) and the forward constants FWD_NONE=00, FWD_MEM_WB=01 and FWD_EX_MEM=10 in shared package hazard_pkg.
REQ-035 SHALL place the forwarding compare logic in sub-module forward_unit, instantiated only under HAZARD_CTRL_FORWARD_EN.

Verification
REQ-036 SHALL cover load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 -> exactly 1 cycle with pc_write=0 and ID_EX_flush=1, and stall_count=1.
REQ-037 SHALL cover a taken branch with BR_FLUSH_CYCLES=2: branch_taken pulse -> IF_ID_flush=1 for 2 consecutive cycles, then the state returns to RUN.
REQ-038 SHALL cover simultaneous events: branch_taken=1 with a load-use match -> flush outputs asserted, pc_write=1, and stall_count unchanged.
REQ-039 SHALL cover x0 writes: EX_MEM_rd=0, EX_MEM_RegWrite=1, ID_EX_rs1=0 -> forward_a=00 and no stall.
REQ-040 SHALL cover forward priority (FORWARD_EN): EX_MEM_rd=MEM_WB_rd=ID_EX_rs1=7, both RegWrite=1 -> forward_a=10.
REQ-041 SHALL cover saturation and reset: with STALL_CNT_W=4 and 20 stalled cycles -> stall_count=15, and reset=0 mid-FLUSH -> state RUN with the counter at 0.
